mesh_traffic_sequencer: RTL and testbench

- On-chip controller that configures, resets, flushes, enables and monitors the 2x4 mesh (8 PEs) for one synthetic traffic pattern per start request.
- Replaces hand-written stimulus sequencing: it generates all PE configuration buses, runs the mesh, waits for the finish flags and reports latency and timeout.
- Sits between a host/debug register block and the mesh top level.

---
 rtl/mesh_traffic_sequencer_pkg.sv | 39 +++
 rtl/mesh_traffic_sequencer_if.sv | 34 +++
 rtl/traffic_pattern_rom.sv | 73 +++++++
 rtl/mesh_traffic_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mesh_traffic_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_traffic_sequencer_pkg.sv
// mesh_pkg: shared constants for the 2x4 mesh traffic sequencer.
//   - Mesh geometry and per-PE configuration slice widths.
//   - Traffic pattern encodings (values 8-15 are illegal).
//   - PE mode encodings and the sequencer FSM state encoding.
package mesh_pkg;

  localparam int PE_NUM      = 8;
  localparam int ADDR_W      = 3;
  localparam int CNT_NUM_W   = 3;
  localparam int MODE_W      = 4;
  localparam int DST_SLICE_W = 24;
  localparam int PAT_W       = 4;

  localparam logic [PAT_W-1:0] PAT_COMPLEMENT = 4'd0;
  localparam logic [PAT_W-1:0] PAT_REVERSE    = 4'd1;
  localparam logic [PAT_W-1:0] PAT_ROTATION   = 4'd2;
  localparam logic [PAT_W-1:0] PAT_SHUFFLE    = 4'd3;
  localparam logic [PAT_W-1:0] PAT_TORNADO    = 4'd4;
  localparam logic [PAT_W-1:0] PAT_NEIGHBOR   = 4'd5;
  localparam logic [PAT_W-1:0] PAT_HOTSPOT    = 4'd6;
  localparam logic [PAT_W-1:0] PAT_TURN       = 4'd7;

  localparam logic [MODE_W-1:0] MODE_ACTIVE = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_TURN   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_FLUSH,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  function automatic logic pattern_legal(input logic [PAT_W-1:0] p);
    return (p <= PAT_TURN);
  endfunction

endpackage

// File: rtl/mesh_traffic_sequencer_if.sv
// Mesh-side bundle of the traffic sequencer.
//   master : sequencer side (drives mesh reset, enables and all PE
//            configuration buses; receives the per-PE finish flags)
//   slave  : mesh side
interface mesh_traffic_sequencer_if;
  import mesh_pkg::*;

  logic                            mesh_rst_n;
  logic [PE_NUM-1:0]               pe_enable;
  logic [PE_NUM-1:0]               pe_dbg_mode_wire;
  logic [PE_NUM*CNT_NUM_W-1:0]     pe_send_num_wire;
  logic [PE_NUM*CNT_NUM_W-1:0]     pe_receive_num_wire;
  logic [PE_NUM*4-1:0]             pe_rate_wire;
  logic [PE_NUM*DST_SLICE_W-1:0]   pe_dst_seq_wire;
  logic [PE_NUM*MODE_W-1:0]        pe_mode_wire;
  logic [PE_NUM-1:0]               pe_flush_wire;
  logic [PE_NUM-1:0]               pe_task_send_finish_flag;
  logic [PE_NUM-1:0]               pe_task_receive_finish_flag;

  modport master (
    output mesh_rst_n, pe_enable, pe_dbg_mode_wire, pe_send_num_wire,
           pe_receive_num_wire, pe_rate_wire, pe_dst_seq_wire, pe_mode_wire,
           pe_flush_wire,
    input  pe_task_send_finish_flag, pe_task_receive_finish_flag
  );

  modport slave (
    input  mesh_rst_n, pe_enable, pe_dbg_mode_wire, pe_send_num_wire,
           pe_receive_num_wire, pe_rate_wire, pe_dst_seq_wire, pe_mode_wire,
           pe_flush_wire,
    output pe_task_send_finish_flag, pe_task_receive_finish_flag
  );

endinterface

// File: rtl/traffic_pattern_rom.sv
// traffic_pattern_rom: combinational map from a traffic pattern code to the
// full set of PE configuration fields.
//   pattern   in  : pattern code (0-7 legal)
//   send_num  out : 3 bits per PE, PE0 at LSB
//   recv_num  out : 3 bits per PE
//   dst_seq   out : 24 bits per PE, destination in the low 3 bits
//   mode      out : 4 bits per PE
//   send_mask out : bit i set when PE i has a nonzero send count
//   recv_mask out : bit i set when PE i has a nonzero receive count
//   legal     out : pattern code is in range
module traffic_pattern_rom
  import mesh_pkg::*;
(
  input  logic [PAT_W-1:0]                pattern,
  output logic [PE_NUM*CNT_NUM_W-1:0]     send_num,
  output logic [PE_NUM*CNT_NUM_W-1:0]     recv_num,
  output logic [PE_NUM*DST_SLICE_W-1:0]   dst_seq,
  output logic [PE_NUM*MODE_W-1:0]        mode,
  output logic [PE_NUM-1:0]               send_mask,
  output logic [PE_NUM-1:0]               recv_mask,
  output logic                            legal
);

  function automatic logic [ADDR_W-1:0] dst_of(input logic [PAT_W-1:0] p,
                                               input logic [ADDR_W-1:0] i);
    case (p)
      PAT_COMPLEMENT: return ~i;
      PAT_REVERSE:    return {i[0], i[1], i[2]};
      PAT_ROTATION:   return {i[0], i[2:1]};
      PAT_SHUFFLE:    return {i[1:0], i[2]};
      PAT_TORNADO:    return i + 3'd3;
      PAT_NEIGHBOR:   return i + 3'd1;
      default:        return '0;
    endcase
  endfunction

  // Hotspot: every PE but PE0 sends one packet to PE0.
  function automatic logic [CNT_NUM_W-1:0] send_of(input logic [PAT_W-1:0] p,
                                                   input logic [ADDR_W-1:0] i);
    if (p <= PAT_NEIGHBOR) return 3'd1;
    if (p == PAT_HOTSPOT)  return (i == '0) ? 3'd0 : 3'd1;
    if (p == PAT_TURN)     return 3'd7;
    return '0;
  endfunction

  // Hotspot: PE0 alone receives the seven packets.
  function automatic logic [CNT_NUM_W-1:0] recv_of(input logic [PAT_W-1:0] p,
                                                   input logic [ADDR_W-1:0] i);
    if (p <= PAT_NEIGHBOR) return 3'd1;
    if (p == PAT_HOTSPOT)  return (i == '0) ? 3'd7 : 3'd0;
    if (p == PAT_TURN)     return 3'd7;
    return '0;
  endfunction

  always_comb begin
    send_num  = '0;
    recv_num  = '0;
    dst_seq   = '0;
    mode      = '0;
    send_mask = '0;
    recv_mask = '0;
    legal     = pattern_legal(pattern);
    for (int i = 0; i < PE_NUM; i++) begin
      dst_seq[i*DST_SLICE_W +: ADDR_W]    = dst_of(pattern, ADDR_W'(i));
      send_num[i*CNT_NUM_W +: CNT_NUM_W]  = send_of(pattern, ADDR_W'(i));
      recv_num[i*CNT_NUM_W +: CNT_NUM_W]  = recv_of(pattern, ADDR_W'(i));
      mode[i*MODE_W +: MODE_W]            = (pattern <= PAT_HOTSPOT) ? MODE_ACTIVE : MODE_TURN;
      send_mask[i] = |send_of(pattern, ADDR_W'(i));
      recv_mask[i] = |recv_of(pattern, ADDR_W'(i));
    end
  end

endmodule

// File: rtl/mesh_traffic_sequencer.sv
// mesh_traffic_sequencer: runs one synthetic traffic pattern on the 2x4 mesh
// per start request: reset -> flush -> settle -> run -> report.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle request, honoured only in IDLE
//   pattern_sel  : traffic pattern (0-7 legal)
//   cfg_rate     : injection rate, replicated into every PE slice
//   mesh         : mesh-side bundle (reset, enables, config buses, flags)
//   busy         : a run is in progress
//   done         : one-cycle pulse at end of run or after an illegal request
//   timeout      : last run hit TIMEOUT (sticky until next start)
//   bad_pattern  : last request had an illegal pattern (sticky)
//   latency      : RUN cycles of the last run, saturating
module mesh_traffic_sequencer
  import mesh_pkg::*;
#(
  parameter int RST_CYC    = 2,
  parameter int FLUSH_CYC  = 4,
  parameter int SETTLE_CYC = 100,
  parameter int TIMEOUT    = 20000,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PAT_W-1:0]       pattern_sel,
  input  logic [3:0]             cfg_rate,
  mesh_traffic_sequencer_if.master mesh,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   bad_pattern,
  output logic [CNT_W-1:0]       latency
);

  localparam int PH_MAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Phase counter reload values: each state lasts (load + 1) cycles.
  localparam logic [PH_W-1:0] RST_LD    = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] FLUSH_LD  = PH_W'(FLUSH_CYC - 1);
  localparam logic [PH_W-1:0] SETTLE_LD = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0] RUN_LD    = PH_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_state_t                    state;
  logic [PH_W-1:0]               phase;
  logic                          bad_done_pend;

  logic                          mesh_rst_n_r;
  logic [PE_NUM-1:0]             pe_enable_r;
  logic [PE_NUM-1:0]             flush_r;
  logic [PE_NUM*CNT_NUM_W-1:0]   send_num_r;
  logic [PE_NUM*CNT_NUM_W-1:0]   recv_num_r;
  logic [PE_NUM*4-1:0]           rate_r;
  logic [PE_NUM*DST_SLICE_W-1:0] dst_r;
  logic [PE_NUM*MODE_W-1:0]      mode_r;
  logic [PE_NUM-1:0]             send_mask_r;
  logic [PE_NUM-1:0]             recv_mask_r;

  logic [PE_NUM*CNT_NUM_W-1:0]   rom_send;
  logic [PE_NUM*CNT_NUM_W-1:0]   rom_recv;
  logic [PE_NUM*DST_SLICE_W-1:0] rom_dst;
  logic [PE_NUM*MODE_W-1:0]      rom_mode;
  logic [PE_NUM-1:0]             rom_send_mask;
  logic [PE_NUM-1:0]             rom_recv_mask;
  logic                          rom_legal;
  logic                          run_complete;

  // The ROM looks at the live request; its outputs are captured only when
  // a start is accepted, which is what "latching the pattern" means here.
  traffic_pattern_rom u_rom (
    .pattern   (pattern_sel),
    .send_num  (rom_send),
    .recv_num  (rom_recv),
    .dst_seq   (rom_dst),
    .mode      (rom_mode),
    .send_mask (rom_send_mask),
    .recv_mask (rom_recv_mask),
    .legal     (rom_legal)
  );

  assign run_complete =
    ((mesh.pe_task_send_finish_flag    & send_mask_r) == send_mask_r) &&
    ((mesh.pe_task_receive_finish_flag & recv_mask_r) == recv_mask_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      phase         <= '0;
      bad_done_pend <= 1'b0;
      mesh_rst_n_r  <= 1'b0;
      pe_enable_r   <= '0;
      flush_r       <= '1;
      send_num_r    <= '0;
      recv_num_r    <= '0;
      rate_r        <= '0;
      dst_r         <= '0;
      mode_r        <= '0;
      send_mask_r   <= '0;
      recv_mask_r   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      bad_pattern   <= 1'b0;
      latency       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          mesh_rst_n_r  <= 1'b1;
          pe_enable_r   <= '0;
          // An illegal request reports its done one cycle after the flag.
          done          <= bad_done_pend;
          bad_done_pend <= 1'b0;
          if (start) begin
            timeout <= 1'b0;
            if (rom_legal) begin
              send_num_r   <= rom_send;
              recv_num_r   <= rom_recv;
              dst_r        <= rom_dst;
              mode_r       <= rom_mode;
              send_mask_r  <= rom_send_mask;
              recv_mask_r  <= rom_recv_mask;
              rate_r       <= {PE_NUM{cfg_rate}};
              bad_pattern  <= 1'b0;
              busy         <= 1'b1;
              mesh_rst_n_r <= 1'b0;
              flush_r      <= '1;
              phase        <= RST_LD;
              state        <= ST_RESET;
            end else begin
              bad_pattern   <= 1'b1;
              bad_done_pend <= 1'b1;
            end
          end
        end
        ST_RESET: begin
          if (phase == '0) begin
            mesh_rst_n_r <= 1'b1;
            phase        <= FLUSH_LD;
            state        <= ST_FLUSH;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        ST_FLUSH: begin
          if (phase == '0) begin
            flush_r <= '0;
            phase   <= SETTLE_LD;
            state   <= ST_SETTLE;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        ST_SETTLE: begin
          if (phase == '0) begin
            pe_enable_r <= '1;
            latency     <= '0;
            phase       <= RUN_LD;
            state       <= ST_RUN;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        ST_RUN: begin
          latency <= sat_inc(latency);
          // Completion is tested first so it wins over a coincident timeout.
          if (run_complete || (phase == '0)) begin
            timeout     <= !run_complete;
            pe_enable_r <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        ST_DONE: begin
          mesh_rst_n_r <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mesh.mesh_rst_n          = mesh_rst_n_r;
  assign mesh.pe_enable           = pe_enable_r;
  assign mesh.pe_dbg_mode_wire    = '1;
  assign mesh.pe_send_num_wire    = send_num_r;
  assign mesh.pe_receive_num_wire = recv_num_r;
  assign mesh.pe_rate_wire        = rate_r;
  assign mesh.pe_dst_seq_wire     = dst_r;
  assign mesh.pe_mode_wire        = mode_r;
  assign mesh.pe_flush_wire       = flush_r;

endmodule

// File: tb/tb_mesh_traffic_sequencer.sv
// Directed bench for mesh_traffic_sequencer. Expected end-of-run reports are
// queued by the stimulus and compared by a monitor on every done pulse.
module tb_mesh_traffic_sequencer;
  import mesh_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  pattern_sel;
  logic [3:0]  cfg_rate;
  logic        busy, done, timeout, bad_pattern;
  logic [15:0] latency;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] lat;
    logic        to;
    logic        bad;
  } exp_t;
  exp_t sb[$];

  mesh_traffic_sequencer_if mesh();

  mesh_traffic_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pattern_sel (pattern_sel),
    .cfg_rate    (cfg_rate),
    .mesh        (mesh),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .bad_pattern (bad_pattern),
    .latency     (latency)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] lat, input logic to, input logic bad);
    exp_t e;
    e.lat = lat; e.to = to; e.bad = bad;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [3:0] p, input logic [3:0] r);
    pattern_sel = p;
    cfg_rate    = r;
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
  endtask

  task automatic wait_enable();
    int n = 0;
    while (mesh.pe_enable !== 8'hFF && n < 300) begin
      tick(1);
      n++;
    end
    chk("wait_enable", mesh.pe_enable, 8'hFF);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 21000) begin
      tick(1);
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic set_flags(input logic [7:0] s, input logic [7:0] r);
    mesh.pe_task_send_finish_flag    = s;
    mesh.pe_task_receive_finish_flag = r;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        chk("done_latency", latency, e.lat);
        chk("done_timeout", timeout, e.to);
        chk("done_bad_pattern", bad_pattern, e.bad);
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mesh_rst_n"}, mesh.mesh_rst_n, 1'b0);
    chk({tag, "_enable"}, mesh.pe_enable, 8'h00);
    chk({tag, "_flush"}, mesh.pe_flush_wire, 8'hFF);
    chk({tag, "_dbg"}, mesh.pe_dbg_mode_wire, 8'hFF);
    chk({tag, "_send"}, mesh.pe_send_num_wire, 24'h0);
    chk({tag, "_recv"}, mesh.pe_receive_num_wire, 24'h0);
    chk({tag, "_rate"}, mesh.pe_rate_wire, 32'h0);
    chk({tag, "_dst"}, mesh.pe_dst_seq_wire, 192'h0);
    chk({tag, "_mode"}, mesh.pe_mode_wire, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_bad"}, bad_pattern, 1'b0);
    chk({tag, "_latency"}, latency, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pattern_sel = 4'd0;
    cfg_rate = 4'd0;
    set_flags(8'h00, 8'h00);
    tick(3);
    chk_reset_values("rst");
    rst_n = 1'b1;
    tick(1);
    chk("idle_mesh_rst_n", mesh.mesh_rst_n, 1'b1);

    // Complement: phase timing and latency 51.
    pulse_start(4'd0, 4'd5);
    chk("cmp_rst_low0", mesh.mesh_rst_n, 1'b0);
    chk("cmp_busy", busy, 1'b1);
    chk("cmp_dst_slice0", mesh.pe_dst_seq_wire[2:0], 3'd7);
    chk("cmp_dst_slice7", mesh.pe_dst_seq_wire[7*24 +: 3], 3'd0);
    chk("cmp_dst_bus", mesh.pe_dst_seq_wire,
        {24'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7});
    chk("cmp_send", mesh.pe_send_num_wire, 24'h249249);
    chk("cmp_recv", mesh.pe_receive_num_wire, 24'h249249);
    chk("cmp_mode", mesh.pe_mode_wire, 32'h11111111);
    chk("cmp_rate", mesh.pe_rate_wire, 32'h55555555);
    tick(1);
    chk("cmp_rst_low1", mesh.mesh_rst_n, 1'b0);
    tick(1);
    chk("cmp_rst_release", mesh.mesh_rst_n, 1'b1);
    chk("cmp_flush_hi0", mesh.pe_flush_wire, 8'hFF);
    tick(3);
    chk("cmp_flush_hi3", mesh.pe_flush_wire, 8'hFF);
    tick(1);
    chk("cmp_flush_drop", mesh.pe_flush_wire, 8'h00);
    tick(99);
    chk("cmp_enable_early", mesh.pe_enable, 8'h00);
    tick(1);
    chk("cmp_enable_at100", mesh.pe_enable, 8'hFF);
    push(16'd51, 1'b0, 1'b0);
    tick(50);
    chk("cmp_latency50", latency, 16'd50);
    set_flags(8'hFF, 8'hFF);
    wait_idle();
    set_flags(8'h00, 8'h00);
    tick(2);
    chk("cmp_latency_hold", latency, 16'd51);
    chk("cmp_enable_off", mesh.pe_enable, 8'h00);

    // Hotspot: masks FE / 01.
    pulse_start(4'd6, 4'd3);
    chk("hot_send", mesh.pe_send_num_wire, 24'h249248);
    chk("hot_recv", mesh.pe_receive_num_wire, 24'h000007);
    chk("hot_dst", mesh.pe_dst_seq_wire, 192'h0);
    wait_enable();
    set_flags(8'hFE, 8'h00);
    tick(5);
    chk("hot_not_complete", busy, 1'b1);
    push(16'd6, 1'b0, 1'b0);
    set_flags(8'hFE, 8'h01);
    wait_idle();
    set_flags(8'h00, 8'h00);
    tick(2);

    // Tornado with no flags: timeout.
    pulse_start(4'd4, 4'd1);
    chk("tor_dst", mesh.pe_dst_seq_wire,
        {24'd2, 24'd1, 24'd0, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3});
    push(16'd20000, 1'b1, 1'b0);
    wait_enable();
    wait_idle();
    tick(3);
    chk("tor_timeout_sticky", timeout, 1'b1);

    // Reverse; start during SETTLE with pattern 5 must be ignored.
    pulse_start(4'd1, 4'd2);
    chk("rev_timeout_clear", timeout, 1'b0);
    chk("rev_dst", mesh.pe_dst_seq_wire,
        {24'd7, 24'd3, 24'd5, 24'd1, 24'd6, 24'd2, 24'd4, 24'd0});
    tick(10);
    pulse_start(4'd5, 4'd9);
    chk("ign_dst", mesh.pe_dst_seq_wire,
        {24'd7, 24'd3, 24'd5, 24'd1, 24'd6, 24'd2, 24'd4, 24'd0});
    chk("ign_rate", mesh.pe_rate_wire, 32'h22222222);
    chk("ign_busy", busy, 1'b1);
    set_flags(8'hFF, 8'hFF);
    push(16'd1, 1'b0, 1'b0);
    wait_enable();
    wait_idle();
    set_flags(8'h00, 8'h00);
    tick(2);

    // Illegal pattern 9.
    push(16'd1, 1'b0, 1'b1);
    pulse_start(4'd9, 4'd0);
    chk("bad_flag", bad_pattern, 1'b1);
    chk("bad_done_not_yet", done, 1'b0);
    chk("bad_mesh_rst_n", mesh.mesh_rst_n, 1'b1);
    tick(1);
    chk("bad_done_pulse", done, 1'b1);
    chk("bad_enable", mesh.pe_enable, 8'h00);
    chk("bad_busy", busy, 1'b0);
    tick(2);

    // Reset in the middle of RUN, then a fresh turn run.
    pulse_start(4'd3, 4'd4);
    chk("shf_bad_clear", bad_pattern, 1'b0);
    wait_enable();
    tick(10);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_reset_values("midrst");
    tick(2);
    set_flags(8'hFF, 8'hFF);
    pulse_start(4'd7, 4'd6);
    chk("turn_send", mesh.pe_send_num_wire, 24'hFFFFFF);
    chk("turn_recv", mesh.pe_receive_num_wire, 24'hFFFFFF);
    chk("turn_mode", mesh.pe_mode_wire, 32'h0);
    push(16'd1, 1'b0, 1'b0);
    wait_enable();
    wait_idle();
    set_flags(8'h00, 8'h00);
    tick(3);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
